avalon_mem_responder: RTL



---
 rtl/nn_bus_pkg.sv | 17 +
 rtl/read_resp_pipe.sv | 63 ++++++
 rtl/avalon_mem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/nn_bus_pkg.sv
// Shared bus definitions for the layer-engine Avalon-MM fabric: widths, address map
// and the word returned for reads that miss the memory window.
package nn_bus_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 32;

   localparam logic [ADDR_W-1:0] IMG_BASE    = 32'd300_000;
   localparam logic [ADDR_W-1:0] LAYER1_BASE = 32'd400_000;
   localparam logic [ADDR_W-1:0] W1_BASE     = 32'd800;

   localparam logic [DATA_W-1:0] DEAD_WORD = 16'hDEAD;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/read_resp_pipe.sv
// Fixed-latency read return path: a shift register of {valid, data} that also keeps
// count of reads accepted but not yet returned.
module read_resp_pipe
   import nn_bus_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MAX_PENDING  = 4,
   localparam int unsigned PEND_W      = $clog2(MAX_PENDING + 1)
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  in_valid,
   input  word_t in_data,
   output logic  out_valid,
   output word_t out_data,
   output logic  full
);

   logic [READ_LATENCY-1:0] valid_q;
   word_t                   data_q [READ_LATENCY];
   logic [PEND_W-1:0]       pending_q;

   // Stage inputs: stage 0 takes the accepted read, stage i takes stage i-1.
   logic [READ_LATENCY-1:0] v_in;
   word_t                   d_in [READ_LATENCY];

   always_comb begin
      v_in[0] = in_valid;
      d_in[0] = in_data;
      for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
         v_in[i+1] = valid_q[i];
         d_in[i+1] = data_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= '0;
         pending_q <= '0;
         for (int i = 0; i < int'(READ_LATENCY); i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(READ_LATENCY); i++) begin
            valid_q[i] <= v_in[i];
            // The output stage only loads real responses so readdata holds between pulses.
            if (v_in[i] || (i != int'(READ_LATENCY) - 1)) begin
               data_q[i] <= d_in[i];
            end
         end
         case ({in_valid, out_valid})
            2'b10:   pending_q <= pending_q + 1'b1;
            2'b01:   pending_q <= pending_q - 1'b1;
            default: pending_q <= pending_q;
         endcase
      end
   end

   assign out_valid = valid_q[READ_LATENCY-1];
   assign out_data  = data_q[READ_LATENCY-1];
   assign full      = (pending_q == PEND_W'(MAX_PENDING));

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave scratch RAM with programmable waitrequest stalls and pipelined
// read latency; doubles as a bus-functional memory model for the layer engines.
module avalon_mem_responder
   import nn_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'd400_000,
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MAX_PENDING  = 4,
   parameter int unsigned WAIT_CYCLES  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [1:0]  byteenable,
   input  logic [31:0] address,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        readdatavalid,
   output logic        waitrequest,
   output logic        err,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_STALL = 1'b1;

   logic              state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;

   logic             cmd, illegal, full;
   logic             accept, rd_acc, wr_acc;
   addr_t            offset;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   word_t            rd_word;
   word_t            mem [DEPTH];

   logic        err_q;
   logic [15:0] rd_count_q, wr_count_q;

   assign cmd     = chipselect & (read_n ^ write_n);
   assign illegal = chipselect & ~read_n & ~write_n;

   // Bit 0 of the byte offset is ignored: the window is word addressed.
   assign offset   = address - BASE_ADDR;
   assign in_range = (address >= BASE_ADDR) && (offset[ADDR_W-1:1] < (ADDR_W-1)'(DEPTH));
   assign idx      = offset[IDX_W:1];

   logic unused_offset_lsb;
   assign unused_offset_lsb = offset[0];

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      waitrequest = 1'b0;
      case (state_q)
         ST_IDLE: begin
            waitrequest = cmd & ((WAIT_CYCLES != 0) | full);
            if (cmd && (WAIT_CYCLES != 0)) begin
               state_d = ST_STALL;
               wcnt_d  = WCNT_W'(WAIT_CYCLES - 1);
            end
         end
         default: begin
            waitrequest = cmd & ((wcnt_q != '0) | full);
            if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - 1'b1;
            end
            if (!cmd || !waitrequest) begin
               state_d = ST_IDLE;
            end
         end
      endcase
      if (reset) begin
         waitrequest = 1'b1;
      end
   end

   assign accept = cmd & ~waitrequest;
   assign rd_acc = accept & ~read_n;
   assign wr_acc = accept & ~write_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wcnt_q     <= '0;
         err_q      <= 1'b0;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         if (illegal || (accept && !in_range)) begin
            err_q <= 1'b1;
         end
         if (rd_acc) begin
            rd_count_q <= rd_count_q + 16'd1;
         end
         if (wr_acc) begin
            wr_count_q <= wr_count_q + 16'd1;
         end
      end
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_acc && in_range) begin
         if (byteenable[0]) begin
            mem[idx][7:0] <= writedata[7:0];
         end
         if (byteenable[1]) begin
            mem[idx][15:8] <= writedata[15:8];
         end
      end
   end

   assign rd_word = in_range ? mem[idx] : DEAD_WORD;

   read_resp_pipe #(
      .READ_LATENCY (READ_LATENCY),
      .MAX_PENDING  (MAX_PENDING)
   ) u_read_resp_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rd_acc),
      .in_data   (rd_word),
      .out_valid (readdatavalid),
      .out_data  (readdata),
      .full      (full)
   );

   assign err      = err_q;
   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;

endmodule
